// File: rtl/dmux16_stream.sv
// dmux16_stream: buffered 1-to-2 stream demultiplexer with a small FIFO per channel.
// Optional per-channel accept counters are built when DMUX16_STATS_EN is defined.
module dmux16_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DMUX16_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [WIDTH-1:0] mem_d    [2][DEPTH];
  logic [AW-1:0]    wr_ptr_q [2];
  logic [AW-1:0]    wr_ptr_d [2];
  logic [AW-1:0]    rd_ptr_q [2];
  logic [AW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic             full_c   [2];
  logic             push_c   [2];
  logic             pop_c    [2];
  logic             oready_c [2];

  assign oready_c[0] = out0_ready;
  assign oready_c[1] = out1_ready;

  // Ready looks only at the addressed channel's registered occupancy (no pop bypass).
  assign full_c[0] = (count_q[0] == CW'(DEPTH));
  assign full_c[1] = (count_q[1] == CW'(DEPTH));
  assign in_ready  = in_sel ? !full_c[1] : !full_c[0];

  assign out0       = mem_q[0][rd_ptr_q[0]];
  assign out1       = mem_q[1][rd_ptr_q[1]];
  assign out0_valid = (count_q[0] != '0);
  assign out1_valid = (count_q[1] != '0);

  // Next-state for both channel FIFOs: push on accept, pop on consumer handshake.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      mem_d[ch]    = mem_q[ch];
      wr_ptr_d[ch] = wr_ptr_q[ch];
      rd_ptr_d[ch] = rd_ptr_q[ch];
      count_d[ch]  = count_q[ch];
      push_c[ch]   = in_valid && in_ready && (in_sel == 1'(ch));
      pop_c[ch]    = (count_q[ch] != '0) && oready_c[ch];
      if (push_c[ch]) begin
        mem_d[ch][wr_ptr_q[ch]] = in;
        wr_ptr_d[ch] = wr_ptr_q[ch] + AW'(1);
      end
      if (pop_c[ch]) begin
        rd_ptr_d[ch] = rd_ptr_q[ch] + AW'(1);
      end
      case ({push_c[ch], pop_c[ch]})
        2'b10:   count_d[ch] = count_q[ch] + CW'(1);
        2'b01:   count_d[ch] = count_q[ch] - CW'(1);
        default: count_d[ch] = count_q[ch];
      endcase
    end
  end

  // FIFO state registers; storage is cleared so both outputs read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[ch][i] <= '0;
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        count_q[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        mem_q[ch]    <= mem_d[ch];
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        count_q[ch]  <= count_d[ch];
      end
    end
  end

`ifdef DMUX16_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Accept counters: clear dominates a same-cycle increment, wrap at 16 bits.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (push_c[0]) cnt0_d = cnt0_q + 16'(1);
      if (push_c[1]) cnt1_d = cnt1_q + 16'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed testbench for dmux16_stream (DEPTH=2); covers counters when DMUX16_STATS_EN is defined.
module tb_dmux16_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0, out1;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
`ifdef DMUX16_STATS_EN
  logic        stats_clr;
  logic [15:0] cnt0, cnt1;
`endif

  int total = 0;
  int bad   = 0;

  dmux16_stream #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0       (out0),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1       (out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DMUX16_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs/outputs are then handled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
`ifdef DMUX16_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_out1", 32'(out1), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Single word to channel 0, then pop it.
    in = 16'h1234; in_sel = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_out0", 32'(out0), 32'h1234);
    chk("t1_v0", 32'(out0_valid), 32'd1);
    chk("t1_v1", 32'(out1_valid), 32'd0);
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;
    chk("t1_v0_pop", 32'(out0_valid), 32'd0);

    // Channel 1 stalled and full; channel 0 still accepts.
    in = 16'hA001; in_sel = 1'b1; in_valid = 1'b1; step();
    in = 16'hA002; step();
    in = 16'hA003; #1;
    chk("t2_rdy_sel1", 32'(in_ready), 32'd0);
    in = 16'hB000; in_sel = 1'b0; #1;
    chk("t2_rdy_sel0", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t2_out0", 32'(out0), 32'hB000);
    chk("t2_v0", 32'(out0_valid), 32'd1);
    chk("t2_out1_a", 32'(out1), 32'hA001);
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    out0_ready = 1'b0;
    chk("t2_out1_b", 32'(out1), 32'hA002);
    chk("t2_v0_empty", 32'(out0_valid), 32'd0);
    step();
    out1_ready = 1'b0;
    chk("t2_v1_empty", 32'(out1_valid), 32'd0);

    // Alternating stream with both consumers always ready.
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in = 16'(i); in_sel = i[0]; in_valid = 1'b1; #1;
      chk($sformatf("t3_rdy_%0d", i), 32'(in_ready), 32'd1);
      step();
      if (i[0]) begin
        chk($sformatf("t3_out1_%0d", i), 32'(out1), 32'(i));
        chk($sformatf("t3_v1_%0d", i), 32'(out1_valid), 32'd1);
        chk($sformatf("t3_v0_%0d", i), 32'(out0_valid), 32'd0);
      end else begin
        chk($sformatf("t3_out0_%0d", i), 32'(out0), 32'(i));
        chk($sformatf("t3_v0_%0d", i), 32'(out0_valid), 32'd1);
        if (i > 0) chk($sformatf("t3_v1_%0d", i), 32'(out1_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    step();
    chk("t3_v0_end", 32'(out0_valid), 32'd0);
    chk("t3_v1_end", 32'(out1_valid), 32'd0);
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Full channel 0: pop and push attempt together; push refused, then accepted.
    in = 16'hC001; in_sel = 1'b0; in_valid = 1'b1; step();
    in = 16'hC002; step();
    in = 16'hC003; out0_ready = 1'b1; #1;
    chk("t4_rdy_full", 32'(in_ready), 32'd0);
    step();
    out0_ready = 1'b0;
    chk("t4_out0_after_pop", 32'(out0), 32'hC002);
    chk("t4_rdy_next", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    out0_ready = 1'b1;
    step();
    chk("t4_out0_c003", 32'(out0), 32'hC003);
    chk("t4_v0_c003", 32'(out0_valid), 32'd1);
    step();
    out0_ready = 1'b0;
    chk("t4_v0_empty", 32'(out0_valid), 32'd0);

    // Asynchronous reset while both channels hold data.
    in = 16'hD001; in_sel = 1'b0; in_valid = 1'b1; step();
    in = 16'hD002; in_sel = 1'b1; step();
    in = 16'hD003; step();
    in_valid = 1'b0;
    chk("t5_pre_v0", 32'(out0_valid), 32'd1);
    chk("t5_pre_rdy1", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t5_v0", 32'(out0_valid), 32'd0);
    chk("t5_v1", 32'(out1_valid), 32'd0);
    chk("t5_rdy", 32'(in_ready), 32'd1);
    chk("t5_out0", 32'(out0), 32'd0);
    chk("t5_out1", 32'(out1), 32'd0);
    step();
    reset = 1'b0;
    step();

`ifdef DMUX16_STATS_EN
    // Counter wrap and clear-over-increment.
    chk("s_cnt0_rst", 32'(cnt0), 32'd0);
    out0_ready = 1'b1; in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in = 16'(i);
      step();
    end
    chk("s_cnt0_ffff", 32'(cnt0), 32'hFFFF);
    step();
    chk("s_cnt0_wrap", 32'(cnt0), 32'd0);
    step(); step(); step();
    chk("s_cnt0_3", 32'(cnt0), 32'd3);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0; in_valid = 1'b0;
    chk("s_cnt0_clr", 32'(cnt0), 32'd0);
    chk("s_cnt1", 32'(cnt1), 32'd0);
    step();
    out0_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux16_stream.md
# dmux16_stream

Buffered 16-bit 1-to-2 demultiplexer: accepts one word per cycle on a valid/ready input and steers it, by a per-word select bit, into one of two independently back-pressured output channels. Each channel has its own small FIFO, so a stalled consumer on one side does not block traffic to the other side unless the incoming word targets the stalled side. It is the distributing counterpart of the 16-bit 2:1 selector and sits where a single producer feeds two datapath consumers.

## Interface

Parameters:
- `WIDTH`, 16, data word width in bits.
- `DEPTH`, 2, per-channel FIFO depth; must be a power of two and at least 2.

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in`  input  WIDTH  incoming word.
- `in_sel`  input  1  destination: 0 sends to channel 0, 1 sends to channel 1.
- `in_valid`  input  1  `in` and `in_sel` are valid.
- `in_ready`  output  1  the block accepts the word this cycle.
- `out0`, `out1`  output  WIDTH  head word of channel 0 / channel 1.
- `out0_valid`, `out1_valid`  output  1  the channel is non-empty.
- `out0_ready`, `out1_ready`  input  1  the consumer takes the head word.
- `stats_clr`  input  1  synchronous clear of the counters (only with `DMUX16_STATS_EN`).
- `cnt0`, `cnt1`  output  16  words accepted per channel (only with `DMUX16_STATS_EN`).

## Operation

- Each channel is a circular FIFO with write pointer, read pointer and occupancy count (0..DEPTH).
- `in_ready` = NOT full of the channel addressed by `in_sel`. It depends combinationally on `in_sel` and registered occupancy only, never on `outX_ready`.
- Push: `in_valid && in_ready` writes `in` into the channel selected by `in_sel`. The other channel is untouched.
- Pop: `outX_valid && outX_ready` advances that channel's read pointer.
- Push and pop on the same channel in the same cycle leave occupancy unchanged. Both pointers advance.
- Pointers wrap modulo DEPTH.
- Order is preserved per channel. There is no ordering guarantee between channels.
- `outX` always shows `mem[rd_ptr]`. Its value is don't-care while `outX_valid` is 0, except that it is 0 after reset.
- `outX_ready` while `outX_valid` is 0 is ignored and does not underflow the FIFO.
- `in_sel` is ignored when `in_valid` is 0.

## Timing

- Reset values: `in_ready` = 1, `out0_valid` = `out1_valid` = 0, `out0` = `out1` = 0, all pointers and counts 0, `cnt0` = `cnt1` = 0.
- Reset mid-operation empties both FIFOs immediately and discards any buffered data.
- Latency: a word accepted at edge N is visible on `outX`, with `outX_valid` = 1, after edge N. It can be popped at edge N+1.
- Throughput: one word per cycle sustained, provided the target channel's consumer keeps pace.
- Full channel: `in_ready` is 0 for words targeting it, even if a pop occurs in the same cycle. No ready bypass is provided. A word targeting the non-full channel is accepted in the same cycle.
- Empty channel: `outX_valid` is 0. There is no same-cycle input-to-output bypass.
- Producer rule: while `in_valid` is 1 and `in_ready` is 0, the producer holds `in` and `in_sel` stable.

## Configuration

- `DMUX16_STATS_EN` defined: the ports `stats_clr`, `cnt0` and `cnt1` exist.
  - `cntX` increments by 1 on every push to channel X.
  - Counters wrap from 0xFFFF to 0x0000.
  - `stats_clr` zeroes both counters at the next edge. Clear wins over a simultaneous increment.
- `DMUX16_STATS_EN` undefined: these ports and their counter logic are absent. Data-path behaviour is identical.

## Test plan

- Reset, then push 0x1234 with sel=0 -> next cycle `out0`=0x1234, `out0_valid`=1, `out1_valid`=0. After a pop, `out0_valid`=0.
- With `out1_ready`=0, push 0xA001 and 0xA002 to channel 1 -> `in_ready`=0 for sel=1 but 1 for sel=0. Push 0xB000 to channel 0, which is accepted. Then raise `out1_ready` -> channel 1 delivers 0xA001 then 0xA002.
- Alternating sel stream 0x0000..0x000F with both readys held at 1 -> one word per cycle. Even words appear on channel 0 in order, odd words on channel 1 in order. No stalls occur.
- Channel 0 full, with simultaneous pop and push-attempt to channel 0 -> push refused (`in_ready`=0), occupancy drops to DEPTH-1. The next cycle the push is accepted.
- Assert reset while both channels hold data -> `out0_valid`=`out1_valid`=0 and `in_ready`=1 without waiting for a clock edge. Outputs read 0.
- With `DMUX16_STATS_EN`: preload `cnt0` to 0xFFFF via 65535 pushes to channel 0, then push once -> `cnt0`=0x0000. Then `stats_clr` and a push in the same cycle -> `cnt0`=0.
